// File: rtl/fetch_btb_unit.sv
// fetch_btb_unit: fetch-stage PC register with a direct-mapped branch target
// buffer (2-bit saturating counters) and mispredict redirect from execute.
// Optional build macro BTB_STATS_EN adds saturating lookup/mispredict counters;
// without it the stat ports are tied to zero.
module fetch_btb_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            pred_taken_out,
  output logic [XLEN-1:0] pred_target_out,
  input  logic            ex_valid,
  input  logic            ex_is_jump,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispredicts
);

  localparam int unsigned IDX  = $clog2(BTB_DEPTH);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  logic [XLEN-1:0] pc_q, pc_d;

  logic            valid_q  [BTB_DEPTH];
  logic [TAGW-1:0] tag_q    [BTB_DEPTH];
  logic [XLEN-1:0] target_q [BTB_DEPTH];
  logic [1:0]      ctr_q    [BTB_DEPTH];

  logic [IDX-1:0]  f_idx;
  logic [TAGW-1:0] f_tag;
  logic            f_hit;
  logic [XLEN-1:0] pc_plus4;

  logic [IDX-1:0]  e_idx;
  logic [TAGW-1:0] e_tag;
  logic            e_hit;
  logic            mis;

  logic            upd_we;
  logic [1:0]      upd_ctr_d;
  logic [XLEN-1:0] upd_tgt_d;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign f_idx    = pc_q[IDX+1:2];
  assign f_tag    = pc_q[XLEN-1:IDX+2];
  assign e_idx    = ex_pc[IDX+1:2];
  assign e_tag    = ex_pc[XLEN-1:IDX+2];

  // Fetch-side lookup and execute-side mispredict detection
  always_comb begin
    f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken_out  = f_hit && ctr_q[f_idx][1];
    pred_target_out = f_hit ? target_q[f_idx] : pc_plus4;
    e_hit           = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    mis             = ex_valid && ((ex_taken != ex_pred_taken) ||
                                   (ex_taken && (ex_target != ex_pred_target)));
  end

  assign pc_out       = pc_q;
  assign pc_plus4_out = pc_plus4;
  assign redirect     = mis;

  // Next fetch PC: stall, then mispredict recovery, then prediction, then +4
  always_comb begin
    pc_d = pc_plus4;
    if (stall) begin
      pc_d = pc_q;
    end else if (mis) begin
      pc_d = ex_taken ? ex_target : (ex_pc + XLEN'(4));
    end else if (pred_taken_out) begin
      pc_d = pred_target_out;
    end
  end

  // BTB entry update computed from the resolved E-stage instruction
  always_comb begin
    upd_we    = 1'b0;
    upd_ctr_d = ctr_q[e_idx];
    upd_tgt_d = target_q[e_idx];
    if (ex_valid && !stall) begin
      if (e_hit) begin
        upd_we = 1'b1;
        if (ex_is_jump) begin
          upd_ctr_d = 2'b11;
          upd_tgt_d = ex_target;
        end else if (ex_taken) begin
          upd_ctr_d = (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'd1;
          upd_tgt_d = ex_target;
        end else begin
          upd_ctr_d = (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        upd_we    = 1'b1;
        upd_ctr_d = ex_is_jump ? 2'b11 : 2'b10;
        upd_tgt_d = ex_target;
      end
    end
  end

  // PC register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // BTB storage; lookups see pre-edge contents on same-index write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
    end else if (upd_we) begin
      valid_q[e_idx]  <= 1'b1;
      tag_q[e_idx]    <= e_tag;
      target_q[e_idx] <= upd_tgt_d;
      ctr_q[e_idx]    <= upd_ctr_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookups_q, mispredicts_q;

  // Saturating event counters, gated by stall so a frozen E stage counts once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lookups_q     <= '0;
      mispredicts_q <= '0;
    end else if (!stall) begin
      if (ex_valid && (lookups_q != '1)) begin
        lookups_q <= lookups_q + 32'd1;
      end
      if (mis && (mispredicts_q != '1)) begin
        mispredicts_q <= mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_mispredicts = mispredicts_q;
`else
  assign stat_lookups     = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_fetch_btb_unit.sv
// Directed, table-driven bench for fetch_btb_unit (XLEN=32, BTB_DEPTH=16).
module tb_fetch_btb_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] pc_out, pc_plus4_out, pred_target_out;
  logic        pred_taken_out;
  logic        ex_valid, ex_is_jump, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        redirect;
  logic [31:0] stat_lookups, stat_mispredicts;

  int checks;
  int failures;

  fetch_btb_unit #(
    .XLEN     (32),
    .BTB_DEPTH(16),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .pc_out          (pc_out),
    .pc_plus4_out    (pc_plus4_out),
    .pred_taken_out  (pred_taken_out),
    .pred_target_out (pred_target_out),
    .ex_valid        (ex_valid),
    .ex_is_jump      (ex_is_jump),
    .ex_pc           (ex_pc),
    .ex_taken        (ex_taken),
    .ex_target       (ex_target),
    .ex_pred_taken   (ex_pred_taken),
    .ex_pred_target  (ex_pred_target),
    .redirect        (redirect),
    .stat_lookups    (stat_lookups),
    .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        ex_valid;
    logic        ex_is_jump;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] exp_pc;
    logic        exp_pt;
    logic [31:0] exp_ptgt;
    logic        exp_red;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input logic ev, input logic jmp, input logic [31:0] epc,
                              input logic tk, input logic [31:0] tgt, input logic ptk,
                              input logic [31:0] ptgt, input logic [31:0] xpc,
                              input logic xpt, input logic [31:0] xptgt, input logic xred);
    vec_t v;
    v.stall = 1'b0; v.ex_valid = ev; v.ex_is_jump = jmp; v.ex_pc = epc;
    v.ex_taken = tk; v.ex_target = tgt; v.ex_pred_taken = ptk; v.ex_pred_target = ptgt;
    v.exp_pc = xpc; v.exp_pt = xpt; v.exp_ptgt = xptgt; v.exp_red = xred;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] xpc, input logic xpt, input logic [31:0] xptgt);
    return mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, xpc, xpt, xptgt, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall          = v.stall;
    ex_valid       = v.ex_valid;
    ex_is_jump     = v.ex_is_jump;
    ex_pc          = v.ex_pc;
    ex_taken       = v.ex_taken;
    ex_target      = v.ex_target;
    ex_pred_taken  = v.ex_pred_taken;
    ex_pred_target = v.ex_pred_target;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, ".pc"},        pc_out,                  v.exp_pc);
    chk({tag, ".pc4"},       pc_plus4_out,            v.exp_pc + 32'd4);
    chk({tag, ".pred_tk"},   {31'b0, pred_taken_out}, {31'b0, v.exp_pt});
    chk({tag, ".pred_tgt"},  pred_target_out,         v.exp_ptgt);
    chk({tag, ".redirect"},  {31'b0, redirect},       {31'b0, v.exp_red});
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled 2 units later.
  task automatic run_vec(input string tag, input vec_t v);
    drive(v);
    #2;
    check_outs(tag, v);
    @(posedge clk);
    #1;
  endtask

  vec_t sv;

  initial begin
    checks   = 0;
    failures = 0;

    // idle/branch/jump vectors: {ev, jmp, ex_pc, taken, target, pred_tk, pred_tgt, exp_pc, exp_pt, exp_ptgt, exp_red}
    vecs[0]  = idle(32'h00, 1'b0, 32'h04);
    vecs[1]  = idle(32'h04, 1'b0, 32'h08);
    vecs[2]  = idle(32'h08, 1'b0, 32'h0C);
    vecs[3]  = mk(1, 0, 32'h08, 1, 32'h40, 0, 32'h0C,  32'h0C,  0, 32'h10,  1); // allocate 0x08->0x40
    vecs[4]  = idle(32'h40, 1'b0, 32'h44);
    vecs[5]  = mk(1, 0, 32'h04, 0, 32'h00, 1, 32'h80,  32'h44,  0, 32'h48,  1); // recover to 0x08
    vecs[6]  = idle(32'h08, 1'b1, 32'h40);                                      // trained: predict taken
    vecs[7]  = mk(1, 0, 32'h08, 0, 32'h00, 1, 32'h40,  32'h40,  0, 32'h44,  1); // ctr 10->01
    vecs[8]  = mk(1, 0, 32'h08, 0, 32'h00, 0, 32'h0C,  32'h0C,  0, 32'h10,  0); // ctr 01->00
    vecs[9]  = mk(1, 0, 32'h04, 0, 32'h00, 1, 32'h80,  32'h10,  0, 32'h14,  1); // back to 0x08
    vecs[10] = idle(32'h08, 1'b0, 32'h40);                                      // valid but not taken
    vecs[11] = idle(32'h0C, 1'b0, 32'h10);
    vecs[12] = mk(1, 0, 32'h08, 1, 32'h40, 0, 32'h0C,  32'h10,  0, 32'h14,  1); // ctr 00->01
    vecs[13] = mk(1, 0, 32'h08, 1, 32'h40, 1, 32'h40,  32'h40,  0, 32'h44,  0); // ctr 01->10, correct
    vecs[14] = mk(1, 1, 32'h48, 1, 32'h100, 0, 32'h4C, 32'h44,  0, 32'h48,  1); // jal 0x48 evicts 0x08
    vecs[15] = mk(1, 0, 32'h04, 0, 32'h00, 1, 32'h80,  32'h100, 0, 32'h104, 1); // back to 0x08
    vecs[16] = idle(32'h08, 1'b0, 32'h0C);                                      // aliased: miss
    vecs[17] = mk(1, 0, 32'h44, 0, 32'h00, 1, 32'h80,  32'h0C,  0, 32'h10,  1); // go to 0x48
    vecs[18] = idle(32'h48, 1'b1, 32'h100);                                     // jump entry ctr=11
    vecs[19] = idle(32'h100, 1'b0, 32'h104);
    vecs[20] = mk(1, 1, 32'h48, 1, 32'h200, 1, 32'h100, 32'h104, 0, 32'h108, 1); // wrong target
    vecs[21] = idle(32'h200, 1'b0, 32'h204);

    // Asynchronous reset before any clock edge
    reset = 1'b0;
    drive(idle(32'h0, 1'b0, 32'h0));
    #2;
    chk("rst.pc",       pc_out,                  32'h0);
    chk("rst.pred_tk",  {31'b0, pred_taken_out}, 32'h0);
    chk("rst.redirect", {31'b0, redirect},       32'h0);
    chk("rst.stat_lk",  stat_lookups,            32'h0);
    chk("rst.stat_mp",  stat_mispredicts,        32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

`ifdef BTB_STATS_EN
    chk("tbl.stat_lk", stat_lookups,     32'd11);
    chk("tbl.stat_mp", stat_mispredicts, 32'd9);
`else
    chk("tbl.stat_lk", stat_lookups,     32'd0);
    chk("tbl.stat_mp", stat_mispredicts, 32'd0);
`endif

    // Stall for 3 cycles with a mispredicting branch at 0x08 held in E
    sv = mk(1, 0, 32'h08, 1, 32'h80, 0, 32'h0C, 32'h204, 0, 32'h208, 1);
    sv.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_vec($sformatf("stall%0d", i), sv);
    end
    sv.stall = 1'b0;
    run_vec("unstall", sv);
    run_vec("after_stall", mk(1, 0, 32'h04, 0, 32'h00, 1, 32'h90, 32'h80, 0, 32'h84, 1));
    run_vec("refetch08", idle(32'h08, 1'b1, 32'h80));

`ifdef BTB_STATS_EN
    chk("stall.stat_lk", stat_lookups,     32'd13);
    chk("stall.stat_mp", stat_mispredicts, 32'd11);
`else
    chk("stall.stat_lk", stat_lookups,     32'd0);
    chk("stall.stat_mp", stat_mispredicts, 32'd0);
`endif

    // Asynchronous reset between edges while pc is 0x80
    chk("pre_rst.pc", pc_out, 32'h80);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.pc",       pc_out,                  32'h0);
    chk("arst.pred_tk",  {31'b0, pred_taken_out}, 32'h0);
    chk("arst.stat_lk",  stat_lookups,            32'h0);
    chk("arst.stat_mp",  stat_mispredicts,        32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold.pc", pc_out, 32'h0);
    reset = 1'b1;
    run_vec("post_rst0", idle(32'h00, 1'b0, 32'h04));
    run_vec("post_rst1", idle(32'h04, 1'b0, 32'h08));
    run_vec("post_rst2", idle(32'h08, 1'b0, 32'h0C)); // previously trained, now cleared
    run_vec("post_rst3", idle(32'h0C, 1'b0, 32'h10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_btb_unit.md
Name: fetch_btb_unit

Overview:
- Parametrised fetch stage for the 5-stage RISC-V pipeline.
- Replaces the fixed PC register and PC+4 adder. Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches and jumps are predicted in F.
- Resolution info arrives from the execute stage. The unit redirects on mispredict and tells the hazard unit to flush D and E.
- The global `stall` (cache miss) freezes all state.

Parameters:
- XLEN, 32, datapath/PC width in bits.
- BTB_DEPTH, 16, number of BTB entries; power of two, minimum 2; IDX = log2(BTB_DEPTH).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; 0 clears all state.
- stall  input  1  global cache stall; 1 freezes PC, BTB and counters.
- pc_out  output  XLEN  current fetch PC (pcF).
- pc_plus4_out  output  XLEN  pcF+4.
- pred_taken_out  output  1  prediction for pcF; carried down the pipe.
- pred_target_out  output  XLEN  predicted target for pcF; carried down the pipe.
- ex_valid  input  1  E stage holds a resolved branch or jump.
- ex_is_jump  input  1  E instruction is jal/jalr.
- ex_pc  input  XLEN  PC of the E instruction.
- ex_taken  input  1  actual outcome (forced 1 for jumps).
- ex_target  input  XLEN  actual target (pc+imm, or ALU result for jalr).
- ex_pred_taken  input  1  prediction made in F for this instruction.
- ex_pred_target  input  XLEN  predicted target made in F for this instruction.
- redirect  output  1  mispredict this cycle; hazard unit flushes D and E.
- stat_lookups  output  32  resolved-branch count (see Optional Feature).
- stat_mispredicts  output  32  mispredict count (see Optional Feature).

Behaviour:
- Reset (reset=0, async, any time including mid-update):
  - pcF=RESET_PC; all BTB valid bits=0; counters=2'b00; stats=0.
  - Outputs: pc_out=RESET_PC, pred_taken_out=0, redirect=0.
- Indexing: index=pcF[IDX+1:2]; tag=pcF[XLEN-1:IDX+2].
- Lookup, combinational on pcF:
  - hit = valid[index] && tag match.
  - pred_taken_out = hit && ctr[index][1].
  - pred_target_out = hit ? target[index] : pcF+4.
- Mispredict, combinational:
  - mis = ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target)).
  - redirect = mis, asserted even while stall=1.
- Next PC, priority order:
  1. stall=1: hold pcF.
  2. mis: load ex_taken ? ex_target : ex_pc+4.
  3. pred_taken_out: load pred_target_out.
  4. Otherwise: load pcF+4.
- PC arithmetic wraps modulo 2^XLEN. No alignment check; bits [1:0] pass through.
- BTB update, clocked, only when ex_valid && !stall. E-stage index/tag are taken from ex_pc.
  - Entry hit, ex_is_jump=1: ctr=2'b11; target=ex_target.
  - Entry hit, branch taken: ctr saturating +1 (max 2'b11); target=ex_target.
  - Entry hit, branch not taken: ctr saturating -1 (min 2'b00); target unchanged; entry stays valid.
  - Entry miss (invalid or tag mismatch), taken: allocate/overwrite. valid=1, tag, target=ex_target, ctr = ex_is_jump ? 2'b11 : 2'b10.
  - Entry miss, not taken: no write.
- While stall=1, E is frozen too and the same update re-presents after the stall. Updating only on !stall prevents double counting.
- Same-cycle lookup and update to one index: the lookup returns pre-edge contents (read-before-write).
- Redirect latency: the new PC is visible on pc_out one clock after redirect=1.

Optional Feature:
- Macro BTB_STATS_EN.
- Defined: two 32-bit saturating counters (hold at 32'hFFFF_FFFF).
  - stat_lookups increments on every ex_valid && !stall.
  - stat_mispredicts increments on every mis && !stall.
  - Both cleared by reset.
- Undefined: stat_lookups and stat_mispredicts tied to 0; no counter flops synthesised; ports remain present.

Test Plan:
- Reset released, stall=0, no ex_valid: pc_out steps 0,4,8,12 on successive clocks; pred_taken_out=0.
- Taken branch at 0x08 resolved in E (ex_taken=1, ex_target=0x40, ex_pred_taken=0):
  - redirect=1 that cycle; pc_out=0x40 next clock.
  - Next fetch of 0x08 gives pred_taken_out=1 and pred_target_out=0x40.
- Same branch resolved not-taken twice: ctr 2'b10 -> 01 -> 00; later fetch of 0x08 predicts not taken (pc+4); entry stays valid.
- stall=1 for 3 cycles with ex_valid=1 and mis=1:
  - pc_out and BTB are unchanged while stalled.
  - Update applies once after stall drops.
  - With BTB_STATS_EN, stat_mispredicts increments by exactly 1.
- Aliasing (BTB_DEPTH=16): addresses 0x08 and 0x48 share an index. Allocating 0x48 evicts 0x08; a fetch of 0x08 then misses and predicts pc+4.
- reset=0 asserted mid-stream, asynchronously between clock edges: pc_out=RESET_PC immediately, and a subsequent fetch of a previously trained PC predicts not taken.
